fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_3000: PC value loaded on reset.
REQ-002 Parameter IM_WORDS, 4096: number of 32-bit words in the instruction memory.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 PC  output  32  current fetch address driven to instruction memory.
REQ-006 instruct  input  32  combinational instruction word returned by instruction memory for PC.
REQ-007 stall  input  1  hold fetch this cycle.
REQ-008 halt  input  1  request permanent stop.
REQ-009 npc_sel  input  2  00 seq, 01 branch, 10 jump, 11 register.
REQ-010 br_taken  input  1  branch condition result.
REQ-011 imm16  input  16  branch offset, in words.
REQ-012 imm26  input  26  jump target index.
REQ-013 ra_value  input  32  register jump target.
REQ-014 instr_out  output  32  captured instruction.
REQ-015 pc_out  output  32  address of instr_out.
REQ-016 pc_plus8  output  32  pc_out+8, the link value.
REQ-017 valid_out  output  1  instr_out/pc_out captured on the last edge.
REQ-018 fetch_cnt  output  32  count of captured instructions.
REQ-019 state  output  2  IDLE=00, FETCH=01, HALT=10.
REQ-020 err  output  1  sticky address fault flag.

Function
REQ-021 The FSM SHALL go IDLE->FETCH unconditionally on the first edge after reset release.
- In IDLE: no capture; PC holds.
REQ-022 In FETCH with stall=0 and halt=0, each edge SHALL load PC<=NPC, instr_out<=instruct, pc_out<=PC, valid_out<=1, fetch_cnt+=1.
REQ-023 In FETCH with stall=1, PC, instr_out, pc_out and fetch_cnt SHALL hold, and valid_out SHALL be 0 after the edge.
REQ-024 NPC SHALL be computed as follows, with all sums modulo 2^32 (PC=32'hFFFF_FFFC seq -> 0):
- 00: PC+4.
- 01: PC+4+(sign_ext(imm16)<<2) if br_taken, else PC+4.
- 10: {PC[31:28], imm26, 2'b00}.
- 11: ra_value.
REQ-025 halt=1 in FETCH SHALL move the FSM to HALT on that edge with no capture, even if stall=1 at the same time (halt wins).
REQ-026 HALT SHALL be exited only by reset.
- In HALT: valid_out=0; PC, instr_out, pc_out and fetch_cnt hold.
REQ-027 pc_plus8 SHALL be combinational pc_out+8, modulo 2^32.
REQ-028 fetch_cnt SHALL saturate at 32'hFFFF_FFFF.
REQ-029 PC SHALL be a register output, with no combinational path from any input to PC.

Reset
REQ-030 Assertion of reset SHALL immediately force all registers, regardless of clk, to:
- PC=RESET_PC, state=IDLE;
- instr_out=0, pc_out=0, valid_out=0;
- fetch_cnt=0, err=0.
REQ-031 Assertion of reset mid-stall or in HALT SHALL behave identically to REQ-030.

Configuration
REQ-032 With macro FETCH_RANGE_CHECK_EN defined, an address fault SHALL be detected when NPC[1:0]!=0 or NPC lies outside [RESET_PC, RESET_PC+4*IM_WORDS-4].
- Check applies only on a would-be update edge (FETCH, stall=0, halt=0).
- On that edge: capture of the current instruction proceeds; PC holds; err<=1 (sticky); state<=HALT.
REQ-033 Without FETCH_RANGE_CHECK_EN, no check SHALL be performed and err SHALL be constant 0 (port retained).

Verification
REQ-034 Release reset, npc_sel=00, no stall -> PC 0x3000, 0x3000, 0x3004, 0x3008; valid_out first 1 after the second edge with pc_out=0x3000, fetch_cnt=1.
REQ-035 PC=0x3010, npc_sel=01, br_taken=1, imm16=16'hFFFE -> next PC=0x300C; same with br_taken=0 -> 0x3014.
REQ-036 PC=0x3020, npc_sel=10, imm26=26'h0000C10 -> next PC=0x0000_3040; npc_sel=11, ra_value=0x3100 -> 0x3100.
REQ-037 stall=1 for 3 cycles at PC=0x3008 -> PC, instr_out and fetch_cnt hold, valid_out=0; stall=0 -> PC=0x300C.
REQ-038 halt=1 with stall=1 -> state=10 next edge, valid_out=0; PC frozen for 10 cycles; reset -> PC=0x3000, state=00.
REQ-039 With FETCH_RANGE_CHECK_EN, npc_sel=11, ra_value=0x3002 -> err=1, state=HALT, PC unchanged; without macro -> PC=0x3002, err=0.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencer with instruction capture and IDLE/FETCH/HALT control
// Ports: clk, reset (async, active-high); PC to instruction memory, instruct back;
//   stall/halt/npc_sel/br_taken/imm16/imm26/ra_value steer the next PC;
//   instr_out/pc_out/pc_plus8/valid_out/fetch_cnt report captures; state and err give status.
// Optional macro FETCH_RANGE_CHECK_EN: fault on a misaligned or out-of-memory next PC.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] PC,
  input  logic [31:0] instruct,
  input  logic        stall,
  input  logic        halt,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] ra_value,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus8,
  output logic        valid_out,
  output logic [31:0] fetch_cnt,
  output logic [1:0]  state,
  output logic        err
);
  typedef enum logic [1:0] {IDLE = 2'b00, FETCH = 2'b01, HALT = 2'b10} state_t;
  localparam logic [31:0] LAST_PC = RESET_PC + 32'(4 * IM_WORDS) - 32'd4;
`ifdef FETCH_RANGE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, pco_q, pco_d, cnt_q, cnt_d;
  logic        valid_q, valid_d, err_q, err_d;
  logic [31:0] seq, npc;
  logic        fault, upd;
  always_comb begin
    seq = pc_q + 32'd4;
    npc = npc_sel == 2'b00 ? seq :
          npc_sel == 2'b01 ? (br_taken ? seq + {{14{imm16[15]}}, imm16, 2'b00} : seq) :
          npc_sel == 2'b10 ? {pc_q[31:28], imm26, 2'b00} : ra_value;
    fault = CHK && (npc[1:0] != 2'b00 || npc < RESET_PC || npc > LAST_PC);
    upd = state_q == FETCH && !stall && !halt;
    // A faulting edge still captures the current instruction but freezes PC and stops.
    state_d = state_q == IDLE ? FETCH :
              (state_q == FETCH && (halt || (upd && fault))) ? HALT : state_q;
    pc_d = (upd && !fault) ? npc : pc_q;
    instr_d = upd ? instruct : instr_q;
    pco_d = upd ? pc_q : pco_q;
    valid_d = upd;
    cnt_d = (upd && !(&cnt_q)) ? cnt_q + 32'd1 : cnt_q;
    err_d = err_q | (upd && fault);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pco_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pco_q   <= pco_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end
  assign PC        = pc_q;
  assign instr_out = instr_q;
  assign pc_out    = pco_q;
  assign pc_plus8  = pco_q + 32'd8;
  assign valid_out = valid_q;
  assign fetch_cnt = cnt_q;
  assign state     = state_q;
  assign err       = err_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table plus hand sequences for halt, reset and range corners
module tb_fetch_unit;
  logic        clk = 1'b0, reset = 1'b1, stall = 1'b0, halt = 1'b0, br_taken = 1'b0;
  logic [1:0]  npc_sel = 2'b00;
  logic [15:0] imm16 = '0;
  logic [25:0] imm26 = '0;
  logic [31:0] ra_value = '0, instruct;
  logic [31:0] pc, instr_out, pc_out, pc_plus8, fetch_cnt;
  logic        valid_out, err;
  logic [1:0]  state;
  int errors = 0, checks = 0;

  fetch_unit dut (
    .clk(clk), .reset(reset), .PC(pc), .instruct(instruct), .stall(stall), .halt(halt),
    .npc_sel(npc_sel), .br_taken(br_taken), .imm16(imm16), .imm26(imm26), .ra_value(ra_value),
    .instr_out(instr_out), .pc_out(pc_out), .pc_plus8(pc_plus8), .valid_out(valid_out),
    .fetch_cnt(fetch_cnt), .state(state), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction
  assign instruct = mem(pc);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic e_v,
                         input logic [31:0] e_pco, input logic [31:0] e_cnt,
                         input logic [1:0] e_st, input logic e_err);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".valid"}, 32'(valid_out), 32'(e_v));
    chk({tag, ".pc_out"}, pc_out, e_pco);
    chk({tag, ".instr"}, instr_out, e_cnt == 0 ? 32'h0 : mem(e_pco));
    chk({tag, ".pc_plus8"}, pc_plus8, e_pco + 32'd8);
    chk({tag, ".cnt"}, fetch_cnt, e_cnt);
    chk({tag, ".state"}, 32'(state), 32'(e_st));
    chk({tag, ".err"}, 32'(err), 32'(e_err));
  endtask

  task automatic step(input logic [1:0] sel, input logic [31:0] ra);
    npc_sel = sel; ra_value = ra; stall = 1'b0; halt = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [1:0] sel; logic tk, st, hl; logic [15:0] i16; logic [25:0] i26; logic [31:0] ra;
    logic [31:0] e_pc; logic e_v; logic [31:0] e_pco, e_cnt; logic [1:0] e_st; logic e_err;
  } vec_t;
  vec_t v[18];

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    v[0]  = '{2'd0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h3000, 0, 32'h0, 32'd0, 2'd1, 0};
    v[1]  = '{2'd0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h3004, 1, 32'h3000, 32'd1, 2'd1, 0};
    v[2]  = '{2'd0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h3008, 1, 32'h3004, 32'd2, 2'd1, 0};
    v[3]  = '{2'd0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h300C, 1, 32'h3008, 32'd3, 2'd1, 0};
    v[4]  = '{2'd0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h3010, 1, 32'h300C, 32'd4, 2'd1, 0};
    v[5]  = '{2'd1, 0, 0, 0, 16'hFFFE, 26'h0, 32'h0, 32'h3014, 1, 32'h3010, 32'd5, 2'd1, 0};
    v[6]  = '{2'd3, 0, 0, 0, 16'h0, 26'h0, 32'h3010, 32'h3010, 1, 32'h3014, 32'd6, 2'd1, 0};
    v[7]  = '{2'd1, 1, 0, 0, 16'hFFFE, 26'h0, 32'h0, 32'h300C, 1, 32'h3010, 32'd7, 2'd1, 0};
    v[8]  = '{2'd3, 0, 0, 0, 16'h0, 26'h0, 32'h3020, 32'h3020, 1, 32'h300C, 32'd8, 2'd1, 0};
    v[9]  = '{2'd2, 0, 0, 0, 16'h0, 26'hC10, 32'h0, 32'h3040, 1, 32'h3020, 32'd9, 2'd1, 0};
    v[10] = '{2'd3, 0, 0, 0, 16'h0, 26'h0, 32'h3100, 32'h3100, 1, 32'h3040, 32'd10, 2'd1, 0};
    v[11] = '{2'd3, 0, 0, 0, 16'h0, 26'h0, 32'h3008, 32'h3008, 1, 32'h3100, 32'd11, 2'd1, 0};
    v[12] = '{2'd0, 0, 1, 0, 16'h0, 26'h0, 32'h0, 32'h3008, 0, 32'h3100, 32'd11, 2'd1, 0};
    v[13] = '{2'd0, 0, 1, 0, 16'h0, 26'h0, 32'h0, 32'h3008, 0, 32'h3100, 32'd11, 2'd1, 0};
    v[14] = '{2'd0, 0, 1, 0, 16'h0, 26'h0, 32'h0, 32'h3008, 0, 32'h3100, 32'd11, 2'd1, 0};
    v[15] = '{2'd0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h300C, 1, 32'h3008, 32'd12, 2'd1, 0};
    v[16] = '{2'd1, 1, 0, 0, 16'h0004, 26'h0, 32'h0, 32'h3020, 1, 32'h300C, 32'd13, 2'd1, 0};
`ifdef FETCH_RANGE_CHECK_EN
    v[17] = '{2'd3, 0, 0, 0, 16'h0, 26'h0, 32'h3002, 32'h3020, 1, 32'h3020, 32'd14, 2'd2, 1};
`else
    v[17] = '{2'd3, 0, 0, 0, 16'h0, 26'h0, 32'h3002, 32'h3002, 1, 32'h3020, 32'd14, 2'd1, 0};
`endif
    #12;
    chk_all("reset", 32'h3000, 0, 32'h0, 32'd0, 2'd0, 0);
    @(negedge clk) reset = 1'b0;
    for (int i = 0; i < 18; i++) begin
      npc_sel = v[i].sel; br_taken = v[i].tk; stall = v[i].st; halt = v[i].hl;
      imm16 = v[i].i16; imm26 = v[i].i26; ra_value = v[i].ra;
      @(posedge clk); #1;
      chk_all($sformatf("vec%0d", i), v[i].e_pc, v[i].e_v, v[i].e_pco, v[i].e_cnt, v[i].e_st, v[i].e_err);
    end
    // halt together with stall: halt wins, then everything freezes until reset
    npc_sel = 2'd0; br_taken = 1'b0; stall = 1'b1; halt = 1'b1;
    @(posedge clk); #1;
    chk_all("halt", v[17].e_pc, 0, 32'h3020, 32'd14, 2'd2, v[17].e_err);
    stall = 1'b0; halt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk($sformatf("halt_hold%0d.pc", i), pc, v[17].e_pc);
      chk($sformatf("halt_hold%0d.state", i), 32'(state), 32'd2);
    end
    chk("halt_hold.cnt", fetch_cnt, 32'd14);
    reset = 1'b1; #2;
    chk_all("arst_halt", 32'h3000, 0, 32'h0, 32'd0, 2'd0, 0);
    @(negedge clk) reset = 1'b0;
    // reset asserted in the middle of a stall
    step(2'd0, 32'h0);
    step(2'd0, 32'h0);
    stall = 1'b1;
    @(posedge clk); #1;
    chk_all("stall_pre", 32'h3004, 0, 32'h3000, 32'd1, 2'd1, 0);
    reset = 1'b1; #2;
    chk_all("arst_stall", 32'h3000, 0, 32'h0, 32'd0, 2'd0, 0);
    @(negedge clk) reset = 1'b0;
    step(2'd0, 32'h0);
`ifdef FETCH_RANGE_CHECK_EN
    step(2'd3, 32'h6FFC);
    chk_all("top_ok", 32'h6FFC, 1, 32'h3000, 32'd1, 2'd1, 0);
    step(2'd0, 32'h0);
    chk_all("top_fault", 32'h6FFC, 1, 32'h6FFC, 32'd2, 2'd2, 1);
`else
    step(2'd3, 32'hFFFF_FFFC);
    chk_all("wrap_pre", 32'hFFFF_FFFC, 1, 32'h3000, 32'd1, 2'd1, 0);
    step(2'd0, 32'h0);
    chk_all("wrap", 32'h0, 1, 32'hFFFF_FFFC, 32'd2, 2'd1, 0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
